// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 key state tracker.
package kbd_pkg;

  typedef logic [1:0] kbd_state_t;

  localparam kbd_state_t ST_IDLE    = 2'd0;
  localparam kbd_state_t ST_EXT     = 2'd1;
  localparam kbd_state_t ST_BRK     = 2'd2;
  localparam kbd_state_t ST_EXT_BRK = 2'd3;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  typedef struct packed {
    logic       valid;
    logic       is_break;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

endpackage

// File: rtl/kbd_prefix_fsm.sv
// PS/2 prefix decoder: folds E0/F0 prefixes into a single decoded make/break
// event, presented combinationally in the same cycle as the final byte strobe.
module kbd_prefix_fsm
  import kbd_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic [7:0] i_Data,
  input  logic       i_Strobe,
  output kbd_event_t o_Event
);

  kbd_state_t r_state;
  kbd_state_t w_next;
  kbd_event_t w_event;
  logic       w_is_ext;
  logic       w_is_brk;

  assign w_is_ext = (i_Data == PS2_EXTEND);
  assign w_is_brk = (i_Data == PS2_BREAK);

  always_comb begin
    w_next         = r_state;
    w_event        = '0;
    w_event.code   = i_Data;
    if (i_Strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_ext)      w_next = ST_EXT;
          else if (w_is_brk) w_next = ST_BRK;
          else               w_event.valid = 1'b1;
        end
        ST_EXT: begin
          if (w_is_brk)      w_next = ST_EXT_BRK;
          else if (w_is_ext) w_next = ST_EXT;
          else begin
            w_event.valid = 1'b1;
            w_event.ext   = 1'b1;
            w_next        = ST_IDLE;
          end
        end
        ST_BRK: begin
          if (w_is_brk)      w_next = ST_BRK;
          else if (w_is_ext) w_next = ST_EXT;
          else begin
            w_event.valid    = 1'b1;
            w_event.is_break = 1'b1;
            w_next           = ST_IDLE;
          end
        end
        default: begin
          // A prefix after E0 F0 is malformed; resynchronise as a fresh extended code.
          if (w_is_ext || w_is_brk) w_next = ST_EXT;
          else begin
            w_event.valid    = 1'b1;
            w_event.is_break = 1'b1;
            w_event.ext      = 1'b1;
            w_next           = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  assign o_Event = w_event;

endmodule

// File: rtl/key_state_tracker.sv
// Multi-key PS/2 make/break tracker with held level, press and release pulses.
// Optional stuck-key forced release is enabled by defining KEY_STUCK_TIMEOUT_EN.
module key_state_tracker
  import kbd_pkg::*;
#(
  parameter int unsigned                NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0]      KEY_CODES      = 32'h75_20_64_61,
  parameter logic [NUM_KEYS-1:0]        EXT_MASK       = 4'b1000,
  parameter int unsigned                TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                i_Clock,
  input  logic                i_Reset_n,
  input  logic [7:0]          i_Data,
  input  logic                rx_done_tick,
  output logic [NUM_KEYS-1:0] o_Held,
  output logic [NUM_KEYS-1:0] o_Press,
  output logic [NUM_KEYS-1:0] o_Release,
  output logic                o_Any_Held,
  output logic                o_Unmapped
);

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("key_state_tracker: NUM_KEYS must be 1..16 and TIMEOUT_CYCLES nonzero");
  end

  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  kbd_event_t          w_event;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_held;
  logic [NUM_KEYS-1:0] w_press;
  logic [NUM_KEYS-1:0] w_release;
  logic                w_any_held;
  logic                w_timeout;
  logic                r_unmapped;

  // Asynchronous assert, release synchronised to i_Clock.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) r_rst_sync <= '0;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  kbd_prefix_fsm u_prefix_fsm (
    .i_Clock   (i_Clock),
    .i_Reset_n (w_rst_n),
    .i_Data    (i_Data),
    .i_Strobe  (rx_done_tick),
    .o_Event   (w_event)
  );

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic r_held;
    logic r_press;
    logic r_release;

    assign w_match[k] = w_event.valid
                     && (w_event.code == KEY_CODES[8*k +: 8])
                     && (w_event.ext  == EXT_MASK[k]);

    always_ff @(posedge i_Clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
        r_held    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else if (w_timeout) begin
        r_held    <= 1'b0;
        r_press   <= 1'b0;
        r_release <= r_held;
      end else begin
        r_press   <= w_match[k] && !w_event.is_break && !r_held;
        r_release <= w_match[k] &&  w_event.is_break &&  r_held;
        if (w_match[k]) r_held <= !w_event.is_break;
      end
    end

    assign w_held[k]    = r_held;
    assign w_press[k]   = r_press;
    assign w_release[k] = r_release;
  end

  assign w_any_held = |w_held;

`ifdef KEY_STUCK_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] r_idle_cnt;

  // Any strobe proves the link is alive, so only strobe-free held time counts.
  assign w_timeout = !rx_done_tick && w_any_held
                  && (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_Clock or negedge w_rst_n) begin
    if (!w_rst_n)                                      r_idle_cnt <= '0;
    else if (rx_done_tick || !w_any_held || w_timeout) r_idle_cnt <= '0;
    else                                               r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_Clock or negedge w_rst_n) begin
    if (!w_rst_n) r_unmapped <= 1'b0;
    else          r_unmapped <= w_event.valid && !(|w_match);
  end

  assign o_Held     = w_held;
  assign o_Press    = w_press;
  assign o_Release  = w_release;
  assign o_Any_Held = w_any_held;
  assign o_Unmapped = r_unmapped;

endmodule

// File: tb/tb_key_state_tracker.sv
// Directed self-checking bench for key_state_tracker (keys 61, 64, 20, E0-75).
module tb_key_state_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       rx;
  logic [3:0] held, press, release_p;
  logic       any_held, unmapped;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  key_state_tracker #(
    .NUM_KEYS       (4),
    .KEY_CODES      (32'h75_20_64_61),
    .EXT_MASK       (4'b1000),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .i_Clock      (clk),
    .i_Reset_n    (rst_n),
    .i_Data       (data),
    .rx_done_tick (rx),
    .o_Held       (held),
    .o_Press      (press),
    .o_Release    (release_p),
    .o_Any_Held   (any_held),
    .o_Unmapped   (unmapped)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] held;
    logic [3:0] press;
    logic [3:0] rel;
    logic       unm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eh, input logic [3:0] ep,
                           input logic [3:0] er, input logic eu);
    chk({tag, " held"},     16'(held),      16'(eh));
    chk({tag, " press"},    16'(press),     16'(ep));
    chk({tag, " release"},  16'(release_p), 16'(er));
    chk({tag, " unmapped"}, 16'(unmapped),  16'(eu));
    chk({tag, " any_held"}, 16'(any_held),  16'(|eh));
  endtask

  // One strobed byte; returns on the negedge after the capturing posedge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    data = b;
    rx   = 1'b1;
    @(negedge clk);
    rx   = 1'b0;
  endtask

  task automatic add(input logic [7:0] d, input logic [3:0] h, input logic [3:0] p,
                     input logic [3:0] r, input logic u);
    vec_t v;
    v.data = d; v.held = h; v.press = p; v.rel = r; v.unm = u;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int drops;
    rst_n = 1'b0;
    rx    = 1'b0;
    data  = 8'h00;

    //    data   held     press    release  unm
    add(8'h61, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    add(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(8'h61, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    add(8'h61, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    add(8'h75, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'h75, 4'b1000, 4'b1000, 4'b0000, 1'b0);
    add(8'hE0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'h75, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    add(8'h61, 4'b0001, 4'b0001, 4'b0000, 1'b0);
    add(8'h64, 4'b0011, 4'b0010, 4'b0000, 1'b0);
    add(8'hF0, 4'b0011, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0010, 4'b0000, 4'b0001, 1'b0);
    add(8'hF0, 4'b0010, 4'b0000, 4'b0000, 1'b0);
    add(8'h64, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    add(8'hF0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'h20, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'h61, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    add(8'hF0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'hE0, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    add(8'h75, 4'b1000, 4'b1000, 4'b0000, 1'b0);
    add(8'hE0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'h75, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'hE0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'hF0, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    add(8'h75, 4'b0000, 4'b0000, 4'b1000, 1'b0);

    repeat (3) @(negedge clk);
    check_all("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].data);
      check_all($sformatf("vec%0d", i), vecs[i].held, vecs[i].press, vecs[i].rel, vecs[i].unm);
    end

    // Press pulse is exactly one cycle wide and held persists.
    send(8'h61);
    check_all("pw_press", 4'b0001, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    check_all("pw_after", 4'b0001, 4'b0000, 4'b0000, 1'b0);

    // Back-to-back strobes: F0 then 61 on consecutive cycles.
    @(negedge clk);
    data = 8'hF0; rx = 1'b1;
    @(negedge clk);
    data = 8'h61;
    check_all("b2b_mid", 4'b0001, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    check_all("b2b_rel", 4'b0000, 4'b0000, 4'b0001, 1'b0);
    @(negedge clk);
    check_all("b2b_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // Reset after a dangling F0 discards it; 61 then decodes as a make.
    send(8'h20);
    send(8'hF0);
    check_all("pre_rst", 4'b0100, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("rst_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    repeat (3) @(negedge clk);
    check_all("rst_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h61);
    check_all("post_rst", 4'b0001, 4'b0001, 4'b0000, 1'b0);
    send(8'hF0);
    send(8'h61);
    check_all("post_rst_rel", 4'b0000, 4'b0000, 4'b0001, 1'b0);

    // Stuck key: hold 20 and stop sending.
    send(8'h20);
    check_all("stuck_press", 4'b0100, 4'b0100, 4'b0000, 1'b0);
`ifdef KEY_STUCK_TIMEOUT_EN
    found = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (release_p[2]) begin
        found = n;
        break;
      end
    end
    chk("timeout_cycle", 16'(found), 16'd100);
    chk("timeout_held", 16'(held), 16'h0000);
    @(negedge clk);
    chk("timeout_pulse_end", 16'(release_p), 16'h0000);
`else
    drops = 0;
    found = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (!held[2]) drops++;
      if (release_p != 4'b0000) found++;
    end
    chk("no_timeout_drops", 16'(drops), 16'd0);
    chk("no_timeout_release", 16'(found), 16'd0);
    chk("no_timeout_held", 16'(held), 16'h0004);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
